// File: rtl/wallace_mul_pkg.sv
// Shared widths and latency constants for the 4x4 Wallace multiplier.
// Latency depends on whether WALLACE_MUL_INREG_EN is defined.
package wallace_mul_pkg;
  localparam int OP_W          = 4;
  localparam int PROD_W        = 8;
  localparam int MUL_LAT_BASE  = 1;
  localparam int MUL_LAT_INREG = 2;
endpackage

// File: rtl/wallace_tree_mul_if.sv
// Operand/product bundle for wallace_tree_mul.
// The master drives operands and the slave returns the product.
interface wallace_tree_mul_if;
  import wallace_mul_pkg::*;

  logic              in_valid;
  logic [OP_W-1:0]   A;
  logic [OP_W-1:0]   B;
  logic              out_valid;
  logic [PROD_W-1:0] Result;

  modport master (
    output in_valid, A, B,
    input  out_valid, Result
  );

  modport slave (
    input  in_valid, A, B,
    output out_valid, Result
  );
endinterface

// File: rtl/wallace_full_adder.sv
// One-bit full adder cell used by the tree and the final ripple adder.
// A half adder is this cell with cin tied low.
module wallace_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/wallace_tree_mul.sv
// Unsigned 4x4 Wallace-tree multiplier with a registered 8-bit product.
// Defining WALLACE_MUL_INREG_EN adds an operand register stage.
module wallace_tree_mul
  import wallace_mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  wallace_tree_mul_if.slave io
);

  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            op_v;

`ifdef WALLACE_MUL_INREG_EN
  logic [OP_W-1:0] a_q, a_d;
  logic [OP_W-1:0] b_q, b_d;
  logic            v_q, v_d;

  always_comb begin
    a_d = io.A;
    b_d = io.B;
    v_d = io.in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      v_q <= v_d;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
  assign op_v = v_q;
`else
  assign op_a = io.A;
  assign op_b = io.B;
  assign op_v = io.in_valid;
`endif

  // pp[i][j] has weight i+j
  logic [OP_W-1:0][OP_W-1:0] pp;

  always_comb begin
    pp = '0;
    for (int i = 0; i < OP_W; i++) begin
      for (int j = 0; j < OP_W; j++) begin
        pp[i][j] = op_a[j] & op_b[i];
      end
    end
  end

  logic s1, c1, s2, c2, s3, c3;

  wallace_full_adder u_l1_w2 (
    .a(pp[0][2]), .b(pp[1][1]), .cin(pp[2][0]),
    .s(s1), .cout(c1)
  );
  wallace_full_adder u_l1_w3 (
    .a(pp[0][3]), .b(pp[1][2]), .cin(pp[2][1]),
    .s(s2), .cout(c2)
  );
  wallace_full_adder u_l1_w4 (
    .a(pp[1][3]), .b(pp[2][2]), .cin(pp[3][1]),
    .s(s3), .cout(c3)
  );

  // w4 uses a half adder so its height stays at 2
  logic s4, c4, sh, ch, s5, c5;

  wallace_full_adder u_l2_w3 (
    .a(s2), .b(pp[3][0]), .cin(c1),
    .s(s4), .cout(c4)
  );
  wallace_full_adder u_l2_w4 (
    .a(s3), .b(c2), .cin(1'b0),
    .s(sh), .cout(ch)
  );
  wallace_full_adder u_l2_w5 (
    .a(pp[2][3]), .b(pp[3][2]), .cin(c3),
    .s(s5), .cout(c5)
  );

  logic [PROD_W-2:0] rx, ry, cs;
  logic k1, k2, k3, k4, k5, k6, k7;

  assign rx = {pp[3][3], s5, sh, s4, s1, pp[0][1], pp[0][0]};
  assign ry = {c5, ch, c4, 1'b0, 1'b0, pp[1][0], 1'b0};

  wallace_full_adder u_cpa0 (
    .a(rx[0]), .b(ry[0]), .cin(1'b0), .s(cs[0]), .cout(k1)
  );
  wallace_full_adder u_cpa1 (
    .a(rx[1]), .b(ry[1]), .cin(k1), .s(cs[1]), .cout(k2)
  );
  wallace_full_adder u_cpa2 (
    .a(rx[2]), .b(ry[2]), .cin(k2), .s(cs[2]), .cout(k3)
  );
  wallace_full_adder u_cpa3 (
    .a(rx[3]), .b(ry[3]), .cin(k3), .s(cs[3]), .cout(k4)
  );
  wallace_full_adder u_cpa4 (
    .a(rx[4]), .b(ry[4]), .cin(k4), .s(cs[4]), .cout(k5)
  );
  wallace_full_adder u_cpa5 (
    .a(rx[5]), .b(ry[5]), .cin(k5), .s(cs[5]), .cout(k6)
  );
  wallace_full_adder u_cpa6 (
    .a(rx[6]), .b(ry[6]), .cin(k6), .s(cs[6]), .cout(k7)
  );

  logic [PROD_W-1:0] res_q, res_d;
  logic              vld_q, vld_d;

  always_comb begin
    res_d = {k7, cs};
    vld_d = op_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end

  assign io.Result    = res_q;
  assign io.out_valid = vld_q;

endmodule

// File: tb/tb_wallace_tree_mul.sv
// Self-checking bench for wallace_tree_mul, table plus scoreboard.
// Latency follows WALLACE_MUL_INREG_EN.
module tb_wallace_tree_mul;
  import wallace_mul_pkg::*;

`ifdef WALLACE_MUL_INREG_EN
  localparam int LAT = MUL_LAT_INREG;
`else
  localparam int LAT = MUL_LAT_BASE;
`endif

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  typedef struct {
    logic       v;
    logic [7:0] p;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  exp_t q[$];
  vec_t tbl[8];

  wallace_tree_mul_if bus ();

  wallace_tree_mul dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // drive one cycle, push expectation, compare the one that is due
  task automatic step(logic v, logic [3:0] a, logic [3:0] b,
                      logic [7:0] p);
    exp_t e;
    exp_t r;
    @(negedge clk);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    e.v = v;
    e.p = p;
    q.push_back(e);
    if (q.size() >= LAT) begin
      r = q.pop_front();
      check("out_valid", int'(bus.out_valid), int'(r.v));
      if (r.v)
        check("result", int'(bus.Result), int'(r.p));
    end
  endtask

  task automatic stepm(logic v, logic [3:0] a, logic [3:0] b);
    logic [7:0] p;
    p = 8'(a) * 8'(b);
    step(v, a, b, p);
  endtask

  task automatic flush();
    for (int i = 0; i < LAT; i++)
      stepm(1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tbl[0] = '{4'd15, 4'd15, 8'd225};
    tbl[1] = '{4'd0,  4'd13, 8'd0};
    tbl[2] = '{4'd1,  4'd9,  8'd9};
    tbl[3] = '{4'd8,  4'd8,  8'd64};
    tbl[4] = '{4'd10, 4'd12, 8'd120};
    tbl[5] = '{4'd7,  4'd9,  8'd63};
    tbl[6] = '{4'd13, 4'd5,  8'd65};
    tbl[7] = '{4'd15, 4'd1,  8'd15};

    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.A        = 4'd15;
    bus.B        = 4'd15;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_result", int'(bus.Result), 0);
      check("rst_valid", int'(bus.out_valid), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].p);
    flush();

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        stepm(1'b1, 4'(a), 4'(b));
    flush();

    stepm(1'b1, 4'd9, 4'd7);
    stepm(1'b0, 4'd9, 4'd7);
    stepm(1'b1, 4'd3, 4'd5);
    stepm(1'b0, 4'd3, 4'd5);
    stepm(1'b1, 4'd9, 4'd7);
    stepm(1'b0, 4'd3, 4'd5);
    flush();

    // async assert mid-cycle with a live product on the output
    for (int i = 0; i <= LAT; i++)
      stepm(1'b1, 4'd15, 4'd15);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_result", int'(bus.Result), 0);
    check("async_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    q.delete();

    // reset pulse while 12*11 is still in flight
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A        = 4'd12;
    bus.B        = 4'd11;
    if (LAT > 1) begin
      @(posedge clk);
      bus.in_valid = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk);
      #1;
      check("no_stale",
            int'(bus.out_valid && bus.Result == 8'd132), 0);
    end
    q.delete();
    stepm(1'b1, 4'd6, 4'd7);
    stepm(1'b1, 4'd12, 4'd11);
    flush();

    for (int i = 0; i < 24; i++)
      stepm(1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
